// File: rtl/main_memory_refill.sv
// Word-addressed backing store serving 4-word cache refills and single-word
// write-throughs, each after a fixed access latency. All outputs are registered.
module main_memory_refill #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_Read_Req,
    input  logic                  Mem_Write_Req,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [31:0]           Data_From_RISC,
    output logic [31:0]           Data_From_Memory,
    output logic [1:0]            block_num_Mem,
    output logic                  Memory_Read_En,
    output logic                  Mem_Done,
    output logic                  Refill_Done,
    output logic                  Write_Done,
    output logic                  Busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_WAIT  = 3'd1;
    localparam logic [2:0] RD_BURST = 3'd2;
    localparam logic [2:0] WR_WAIT  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
    logic [2:0]            state;
    logic [3:0]            cnt;
    logic [1:0]            beat;
    logic [1:0]            next_beat;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  wr_commit;

    assign next_beat     = beat + 2'd1;
    assign block_num_Mem = beat;
    assign wr_commit     = (state == WR_WAIT) && (cnt == 4'd0) && !rst;

    // The array has no reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[addr] <= wdata;
        end
    end

    // beat always names the word currently presented on Data_From_Memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            beat             <= 2'd0;
            addr             <= '0;
            wdata            <= 32'd0;
            Data_From_Memory <= 32'd0;
            Memory_Read_En   <= 1'b0;
            Mem_Done         <= 1'b0;
            Refill_Done      <= 1'b0;
            Write_Done       <= 1'b0;
            Busy             <= 1'b0;
        end else begin
            Mem_Done    <= 1'b0;
            Refill_Done <= 1'b0;
            Write_Done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Mem_Write_Req) begin
                        state <= WR_WAIT;
                        addr  <= Mem_Addr;
                        wdata <= Data_From_RISC;
                        cnt   <= CNT_LOAD;
                        Busy  <= 1'b1;
                    end else if (Mem_Read_Req) begin
                        state          <= RD_WAIT;
                        addr           <= Mem_Addr;
                        cnt            <= CNT_LOAD;
                        Busy           <= 1'b1;
                        Memory_Read_En <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        state            <= RD_BURST;
                        beat             <= 2'd0;
                        Data_From_Memory <= mem[{addr[ADDR_WIDTH-1:2], 2'd0}];
                        Mem_Done         <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_BURST: begin
                    if (beat == 2'd3) begin
                        state          <= DONE;
                        Refill_Done    <= 1'b1;
                        Memory_Read_En <= 1'b0;
                    end else begin
                        beat             <= next_beat;
                        Data_From_Memory <= mem[{addr[ADDR_WIDTH-1:2], next_beat}];
                        Mem_Done         <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= DONE;
                        Write_Done <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    Busy           <= 1'b0;
                    Memory_Read_En <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_refill.sv
// Directed self-checking bench for main_memory_refill: refill timing, beat order,
// write-through, priority, busy rejection, mid-burst reset and latency extremes.
module tb_main_memory_refill;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = 32'd0;
    logic          rd_req_l1 = 1'b0;
    logic          rd_req_l15 = 1'b0;
    logic          zero_bit = 1'b0;

    logic [31:0] rdata;
    logic [1:0]  blk;
    logic        mre, mdone, rdone, wdone, busy;

    logic [31:0] rdata_l1, rdata_l15;
    logic [1:0]  blk_l1, blk_l15;
    logic        mre_l1, mdone_l1, rdone_l1, wdone_l1, busy_l1;
    logic        mre_l15, mdone_l15, rdone_l15, wdone_l15, busy_l15;

    logic sw_sel = 1'b0;
    logic sw_done, sw_refill;
    assign sw_done   = sw_sel ? mdone_l15 : mdone_l1;
    assign sw_refill = sw_sel ? rdone_l15 : rdone_l1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_memory_refill #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Mem_Read_Req(rd_req), .Mem_Write_Req(wr_req),
        .Mem_Addr(addr), .Data_From_RISC(wdata), .Data_From_Memory(rdata),
        .block_num_Mem(blk), .Memory_Read_En(mre), .Mem_Done(mdone),
        .Refill_Done(rdone), .Write_Done(wdone), .Busy(busy)
    );

    main_memory_refill #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .Mem_Read_Req(rd_req_l1), .Mem_Write_Req(zero_bit),
        .Mem_Addr(addr), .Data_From_RISC(wdata), .Data_From_Memory(rdata_l1),
        .block_num_Mem(blk_l1), .Memory_Read_En(mre_l1), .Mem_Done(mdone_l1),
        .Refill_Done(rdone_l1), .Write_Done(wdone_l1), .Busy(busy_l1)
    );

    main_memory_refill #(.ADDR_WIDTH(AW), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .Mem_Read_Req(rd_req_l15), .Mem_Write_Req(zero_bit),
        .Mem_Addr(addr), .Data_From_RISC(wdata), .Data_From_Memory(rdata_l15),
        .block_num_Mem(blk_l15), .Memory_Read_En(mre_l15), .Mem_Done(mdone_l15),
        .Refill_Done(rdone_l15), .Write_Done(wdone_l15), .Busy(busy_l15)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a,
                                 input logic [31:0] d);
        rd_req = rd;
        wr_req = wr;
        addr   = a;
        wdata  = d;
    endtask

    // Write one word, expecting Write_Done LAT cycles after the accept edge.
    task automatic doWrite(input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        applyStimulus(1'b0, 1'b1, a, d);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wdone && n < 40);
        checkOutput("wr_latency", 32'(n), 32'(LAT + 1));
        applyStimulus(1'b0, 1'b0, a, 32'd0);
        tick();
        checkOutput("wr_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Read a block; lead is the tick count from request to the first beat.
    task automatic doRead(input logic [AW-1:0] a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input int lead);
        logic [31:0] exp [4];
        int n;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        applyStimulus(1'b1, 1'b0, a, 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mdone && n < 60);
        checkOutput("rd_first_beat", 32'(n), 32'(lead));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checkOutput("rd_mem_done", {31'd0, mdone}, 32'd1);
            checkOutput("rd_block_num", {30'd0, blk}, 32'(k));
            checkOutput("rd_data", rdata, exp[k]);
            checkOutput("rd_read_en", {31'd0, mre}, 32'd1);
            checkOutput("rd_no_early_refill", {31'd0, rdone}, 32'd0);
        end
        tick();
        checkOutput("rd_refill_done", {31'd0, rdone}, 32'd1);
        checkOutput("rd_done_no_beat", {31'd0, mdone}, 32'd0);
        checkOutput("rd_done_read_en", {31'd0, mre}, 32'd0);
        checkOutput("rd_done_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, a, 32'd0);
        tick();
        checkOutput("rd_refill_pulse", {31'd0, rdone}, 32'd0);
        checkOutput("rd_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic measureSweep(input logic sel, input int lat);
        int n;
        int beats;
        int refills;
        sw_sel = sel;
        if (sel) rd_req_l15 = 1'b1; else rd_req_l1 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sw_done && n < 60);
        checkOutput(sel ? "sweep15_first_beat" : "sweep1_first_beat", 32'(n), 32'(lat + 1));
        beats = sw_done ? 1 : 0;
        refills = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sw_done) beats++;
            if (sw_refill) begin
                refills++;
                rd_req_l1  = 1'b0;
                rd_req_l15 = 1'b0;
            end
        end
        checkOutput(sel ? "sweep15_beats" : "sweep1_beats", 32'(beats), 32'd4);
        checkOutput(sel ? "sweep15_refills" : "sweep1_refills", 32'(refills), 32'd1);
    endtask

    initial begin
        int n;
        int beats;
        int wdones;

        tick();
        tick();
        checkOutput("reset_data", rdata, 32'd0);
        checkOutput("reset_block", {30'd0, blk}, 32'd0);
        checkOutput("reset_flags", {27'd0, mre, mdone, rdone, wdone, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Preload blocks used later.
        for (int i = 0; i < 4; i++) doWrite(AW'(10'h010 + i), 32'hA0A0_0000 + 32'(i));
        for (int i = 0; i < 4; i++) doWrite(AW'(10'h020 + i), 32'hB0B0_0000 + 32'(i));
        for (int i = 0; i < 3; i++) doWrite(AW'(10'h3FC + i), 32'hC0C0_0000 + 32'(i));

        // Refill from an unaligned address still starts at beat 0.
        doRead(10'h012, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, LAT + 1);

        // Reset while beat 1 is on the bus.
        applyStimulus(1'b1, 1'b0, 10'h012, 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mdone && blk == 2'd1) && n < 60);
        checkOutput("rst_reached_beat1", 32'(n), 32'(LAT + 2));
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'h000, 32'd0);
        tick();
        checkOutput("rst_mid_data", rdata, 32'd0);
        checkOutput("rst_mid_block", {30'd0, blk}, 32'd0);
        checkOutput("rst_mid_flags", {27'd0, mre, mdone, rdone, wdone, busy}, 32'd0);
        rst = 1'b0;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mdone) beats++;
        end
        checkOutput("rst_no_more_beats", 32'(beats), 32'd0);
        doRead(10'h013, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, LAT + 1);

        // Top-of-array word lands as beat 3.
        doWrite(10'h3FF, 32'hDEAD_BEEF);
        doRead(10'h3FC, 32'hC0C0_0000, 32'hC0C0_0001, 32'hC0C0_0002, 32'hDEAD_BEEF, LAT + 1);

        // Simultaneous requests: write first, then the held read.
        applyStimulus(1'b1, 1'b1, 10'h022, 32'hCAFE_F00D);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wdone && n < 40);
        checkOutput("prio_write_first", 32'(n), 32'(LAT + 1));
        checkOutput("prio_no_read_en", {31'd0, mre}, 32'd0);
        doRead(10'h022, 32'hB0B0_0000, 32'hB0B0_0001, 32'hCAFE_F00D, 32'hB0B0_0003, LAT + 2);

        // Read pulse during a busy write is dropped.
        applyStimulus(1'b0, 1'b1, 10'h050, 32'h1234_5678);
        tick();
        applyStimulus(1'b1, 1'b1, 10'h050, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 1'b1, 10'h050, 32'h1234_5678);
        beats = 0;
        wdones = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mdone) beats++;
            if (wdone) begin
                wdones++;
                applyStimulus(1'b0, 1'b0, 10'h050, 32'd0);
            end
        end
        checkOutput("busy_read_ignored", 32'(beats), 32'd0);
        checkOutput("busy_write_done_once", 32'(wdones), 32'd1);
        checkOutput("busy_idle_after", {31'd0, busy}, 32'd0);

        measureSweep(1'b0, 1);
        measureSweep(1'b1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
